// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, drives the instruction SRAM port
// and buffers one instruction for decode, tracking delay slots and flushes.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] EX_ENTRY = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic        br_bus_en,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        flush_ex,
    input  logic        flush_eret,
    input  logic [31:0] c0_epc,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic        fs_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_bd,
    output logic        fs_ex,
    output logic [4:0]  fs_exccode,
    output logic [31:0] fs_badvaddr
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, CANCEL} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        bd;
        logic        ex;
        logic [4:0]  exccode;
        logic [31:0] badvaddr;
    } fs_buf_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        br_pending, br_pending_n;
    logic        br_taken_q, br_taken_n;
    logic [31:0] br_target_q, br_target_n;
    logic        redirect_valid, redirect_valid_n;
    logic [31:0] redirect_pc, redirect_pc_n;
    fs_buf_t     buf_q, buf_n;

    logic        flush;
    logic [31:0] flush_pc;
    logic        misaligned;
    logic        deliver;
    logic        cap_bd;
    logic [31:0] next_pc;

    assign flush      = flush_ex | flush_eret;
    assign flush_pc   = flush_ex ? EX_ENTRY : c0_epc;
    assign misaligned = pc[1:0] != 2'b00;
    assign deliver    = (state == HOLD) & ds_allowin;
    assign cap_bd     = br_pending | br_bus_en;

    always_comb begin
        if (br_pending && br_taken_q)
            next_pc = br_target_q;
        else if (br_bus_en && br_taken)
            next_pc = br_target;
        else
            next_pc = pc + 32'd4;
    end

    always_comb begin
        state_n          = state;
        pc_n             = pc;
        br_pending_n     = br_pending;
        br_taken_n       = br_taken_q;
        br_target_n      = br_target_q;
        redirect_valid_n = redirect_valid;
        redirect_pc_n    = redirect_pc;
        buf_n            = buf_q;

        if (br_bus_en && !deliver) begin
            br_pending_n = 1'b1;
            br_taken_n   = br_taken;
            br_target_n  = br_target;
        end

        unique case (state)
            IDLE: begin
                state_n = REQ;
                if (flush) pc_n = flush_pc;
            end
            REQ: begin
                if (misaligned) begin
                    if (flush) begin
                        pc_n = flush_pc;
                    end else begin
                        buf_n.pc       = pc;
                        buf_n.inst     = 32'h0;
                        buf_n.bd       = cap_bd;
                        buf_n.ex       = 1'b1;
                        buf_n.exccode  = 5'h04;
                        buf_n.badvaddr = pc;
                        state_n        = HOLD;
                    end
                end else begin
                    // the address is held until accepted; redirect is deferred
                    if (flush) begin
                        redirect_valid_n = 1'b1;
                        redirect_pc_n    = flush_pc;
                    end
                    if (inst_sram_addr_ok)
                        state_n = (flush || redirect_valid) ? CANCEL : WAIT;
                end
            end
            WAIT: begin
                if (inst_sram_data_ok) begin
                    if (flush) begin
                        pc_n    = flush_pc;
                        state_n = REQ;
                    end else begin
                        buf_n.pc       = pc;
                        buf_n.inst     = inst_sram_rdata;
                        buf_n.bd       = cap_bd;
                        buf_n.ex       = 1'b0;
                        buf_n.exccode  = 5'h00;
                        buf_n.badvaddr = 32'h0;
                        state_n        = HOLD;
                    end
                end else if (flush) begin
                    redirect_valid_n = 1'b1;
                    redirect_pc_n    = flush_pc;
                    state_n          = CANCEL;
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_n    = flush_pc;
                    state_n = REQ;
                end else if (ds_allowin) begin
                    pc_n         = next_pc;
                    br_pending_n = 1'b0;
                    state_n      = REQ;
                end
            end
            CANCEL: begin
                if (flush) redirect_pc_n = flush_pc;
                if (inst_sram_data_ok) begin
                    pc_n             = flush ? flush_pc : redirect_pc;
                    redirect_valid_n = 1'b0;
                    state_n          = REQ;
                end
            end
            default: state_n = IDLE;
        endcase

        if (flush) br_pending_n = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            br_pending     <= 1'b0;
            br_taken_q     <= 1'b0;
            br_target_q    <= 32'h0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
            buf_q          <= '0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            br_pending     <= br_pending_n;
            br_taken_q     <= br_taken_n;
            br_target_q    <= br_target_n;
            redirect_valid <= redirect_valid_n;
            redirect_pc    <= redirect_pc_n;
            buf_q          <= buf_n;
        end
    end

    assign inst_sram_req  = (state == REQ) & ~misaligned;
    assign inst_sram_addr = pc;
    assign fs_valid       = state == HOLD;
    assign fs_pc          = buf_q.pc;
    assign fs_inst        = buf_q.inst;
    assign fs_bd          = buf_q.bd | ((state == HOLD) & br_bus_en);
    assign fs_ex          = buf_q.ex;
    assign fs_exccode     = buf_q.exccode;
    assign fs_badvaddr    = buf_q.badvaddr;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: table of fetch records against a delay-configurable
// instruction memory model, plus hand sequences for flush and reset cases.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_allowin;
    logic        br_bus_en;
    logic        br_taken;
    logic [31:0] br_target;
    logic        flush_ex;
    logic        flush_eret;
    logic [31:0] c0_epc;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_bd;
    logic        fs_ex;
    logic [4:0]  fs_exccode;
    logic [31:0] fs_badvaddr;

    always #5 clk = ~clk;

    if_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ds_allowin        (ds_allowin),
        .br_bus_en         (br_bus_en),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .flush_ex          (flush_ex),
        .flush_eret        (flush_eret),
        .c0_epc            (c0_epc),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .fs_valid          (fs_valid),
        .fs_pc             (fs_pc),
        .fs_inst           (fs_inst),
        .fs_bd             (fs_bd),
        .fs_ex             (fs_ex),
        .fs_exccode        (fs_exccode),
        .fs_badvaddr       (fs_badvaddr)
    );

    typedef struct {
        int          addr_lat;
        int          data_lat;
        int          stall;
        int          br_mode;
        logic        br_tk;
        logic [31:0] br_tgt;
        logic [31:0] exp_pc;
        logic        exp_bd;
        logic        exp_ex;
        int          exp_cyc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        bd;
        logic        ex;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_addr[$];
    vec_t        vecs[10];

    int n_checks = 0;
    int n_pass   = 0;
    int mem_alat = 0;
    int mem_dlat = 1;
    int req_cnt  = 0;
    int pend_cnt = 0;
    bit pend     = 1'b0;
    logic [31:0] pend_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    function automatic vec_t mk(input logic [31:0] pc, input int cyc);
        vec_t v;
        v.addr_lat = 0;
        v.data_lat = 1;
        v.stall    = 0;
        v.br_mode  = 0;
        v.br_tk    = 1'b0;
        v.br_tgt   = 32'h0;
        v.exp_pc   = pc;
        v.exp_bd   = 1'b0;
        v.exp_ex   = 1'b0;
        v.exp_cyc  = cyc;
        return v;
    endfunction

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // One clock: memory responds at negedge, scoreboards checked just after.
    task automatic cycle(output bit delivered);
        bit          acc, dok, rq;
        logic [31:0] a, ea;
        exp_t        e;
        delivered = 1'b0;
        @(negedge clk);
        inst_sram_addr_ok = inst_sram_req && (req_cnt >= mem_alat);
        inst_sram_data_ok = pend && (pend_cnt == 0);
        inst_sram_rdata   = inst_sram_data_ok ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        #1;
        rq  = inst_sram_req;
        acc = inst_sram_req && inst_sram_addr_ok;
        dok = inst_sram_data_ok;
        a   = inst_sram_addr;
        if (acc) begin
            check(!pend || dok, "one_outstanding", a, pend_addr);
            check(exp_addr.size() != 0, "unexpected_req", a, 32'h0);
            if (exp_addr.size() != 0) begin
                ea = exp_addr.pop_front();
                check(a == ea, "req_addr", a, ea);
            end
        end
        if (fs_valid && ds_allowin) begin
            delivered = 1'b1;
            check(exp_q.size() != 0, "unexpected_delivery", fs_pc, 32'h0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(fs_pc == e.pc, "fs_pc", fs_pc, e.pc);
                check(fs_inst == e.inst, "fs_inst", fs_inst, e.inst);
                check(fs_bd == e.bd, "fs_bd", {31'b0, fs_bd}, {31'b0, e.bd});
                check(fs_ex == e.ex, "fs_ex", {31'b0, fs_ex}, {31'b0, e.ex});
                if (e.ex) begin
                    check(fs_exccode == 5'h04, "fs_exccode", {27'b0, fs_exccode}, 32'h4);
                    check(fs_badvaddr == e.pc, "fs_badvaddr", fs_badvaddr, e.pc);
                end
            end
        end
        @(posedge clk);
        #1;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            pend_addr = a;
            pend_cnt  = mem_dlat - 1;
        end else if (dok) begin
            pend = 1'b0;
        end else if (pend && pend_cnt > 0) begin
            pend_cnt--;
        end
        req_cnt = (rq && !acc) ? req_cnt + 1 : 0;
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc  = 0;
        int   held = 0;
        bit   done = 1'b0;
        bit   brd  = 1'b0;
        exp_t e;
        mem_alat = v.addr_lat;
        mem_dlat = v.data_lat;
        if (!v.exp_ex) exp_addr.push_back(v.exp_pc);
        e.pc   = v.exp_pc;
        e.inst = v.exp_ex ? 32'h0 : mem_word(v.exp_pc);
        e.bd   = v.exp_bd;
        e.ex   = v.exp_ex;
        exp_q.push_back(e);
        while (!done && cyc < 40) begin
            br_bus_en  = 1'b0;
            br_taken   = 1'b0;
            br_target  = 32'h0;
            ds_allowin = fs_valid && (held >= v.stall);
            if (fs_valid && !ds_allowin) begin
                held++;
                check(!inst_sram_req && fs_pc == v.exp_pc && fs_inst == mem_word(v.exp_pc),
                      "hold_stable", fs_pc, v.exp_pc);
            end
            if (!brd && ((v.br_mode == 1 && pend) || (v.br_mode == 2 && ds_allowin))) begin
                brd       = 1'b1;
                br_bus_en = 1'b1;
                br_taken  = v.br_tk;
                br_target = v.br_tgt;
            end
            cycle(done);
            if (done) check(cyc == v.exp_cyc, "latency", cyc, v.exp_cyc);
            cyc++;
        end
        br_bus_en = 1'b0;
        check(done, "deliver_timeout", cyc, v.exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit   d;
        int   n;
        vec_t v;

        reset             = 1'b1;
        ds_allowin        = 1'b0;
        br_bus_en         = 1'b0;
        br_taken          = 1'b0;
        br_target         = 32'h0;
        flush_ex          = 1'b0;
        flush_eret        = 1'b0;
        c0_epc            = 32'h0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;

        vecs[0] = mk(32'hBFC0_0000, 3);
        vecs[1] = mk(32'hBFC0_0004, 2);
        vecs[2] = mk(32'hBFC0_0008, 2);
        vecs[3] = mk(32'hBFC0_000C, 7);
        vecs[3].stall = 5;
        vecs[4] = mk(32'hBFC0_0010, 4);
        vecs[4].addr_lat = 1;
        vecs[4].data_lat = 2;
        vecs[4].br_mode  = 1;
        vecs[4].br_tk    = 1'b1;
        vecs[4].br_tgt   = 32'h8000_1000;
        vecs[4].exp_bd   = 1'b1;
        vecs[5] = mk(32'h8000_1000, 2);
        vecs[6] = mk(32'h8000_1004, 2);
        vecs[6].br_mode = 2;
        vecs[6].br_tgt  = 32'h1234_5678;
        vecs[6].exp_bd  = 1'b1;
        vecs[7] = mk(32'h8000_1008, 2);
        vecs[8] = mk(32'h8000_100C, 2);
        vecs[8].br_mode = 2;
        vecs[8].br_tk   = 1'b1;
        vecs[8].br_tgt  = 32'h8000_0002;
        vecs[8].exp_bd  = 1'b1;
        vecs[9] = mk(32'h8000_0002, 1);
        vecs[9].exp_ex = 1'b1;

        @(posedge clk);
        #1;
        repeat (3) cycle(d);
        reset = 1'b0;
        check(!inst_sram_req, "rst_req", {31'b0, inst_sram_req}, 32'h0);
        check(!fs_valid, "rst_valid", {31'b0, fs_valid}, 32'h0);
        check(!fs_bd, "rst_bd", {31'b0, fs_bd}, 32'h0);
        check(!fs_ex, "rst_ex", {31'b0, fs_ex}, 32'h0);
        check(fs_exccode == 5'h00, "rst_exccode", {27'b0, fs_exccode}, 32'h0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // ERET flush while the misaligned fetch at 80000006 is held
        ds_allowin = 1'b0;
        n = 0;
        while (!fs_valid && n < 10) begin
            cycle(d);
            n++;
        end
        check(fs_valid && fs_ex && fs_pc == 32'h8000_0006, "misalign_hold", fs_pc, 32'h8000_0006);
        flush_eret = 1'b1;
        c0_epc     = 32'h8000_0200;
        cycle(d);
        flush_eret = 1'b0;
        check(!fs_valid, "eret_clears_valid", {31'b0, fs_valid}, 32'h0);
        run_vec(mk(32'h8000_0200, 2));

        // exception flush while waiting; the late data must be dropped
        ds_allowin = 1'b0;
        mem_alat   = 0;
        mem_dlat   = 3;
        exp_addr.push_back(32'h8000_0204);
        cycle(d);
        flush_ex = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check(!fs_valid && !inst_sram_req, "cancel_quiet",
                  {30'b0, fs_valid, inst_sram_req}, 32'h0);
            cycle(d);
            flush_ex = 1'b0;
        end
        check(!fs_valid, "flush_no_present", {31'b0, fs_valid}, 32'h0);
        run_vec(mk(32'hBFC0_0380, 2));

        // flush in REQ before addr_ok: address held, ex wins over eret
        ds_allowin = 1'b0;
        mem_alat   = 3;
        mem_dlat   = 1;
        exp_addr.push_back(32'hBFC0_0384);
        flush_ex   = 1'b1;
        flush_eret = 1'b1;
        c0_epc     = 32'h8000_0300;
        cycle(d);
        flush_ex   = 1'b0;
        flush_eret = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check(inst_sram_req && inst_sram_addr == 32'hBFC0_0384, "addr_hold",
                  inst_sram_addr, 32'hBFC0_0384);
            cycle(d);
        end
        check(!inst_sram_req && !fs_valid, "cancel_no_req",
              {30'b0, fs_valid, inst_sram_req}, 32'h0);
        cycle(d);
        run_vec(mk(32'hBFC0_0380, 2));

        // reset while a request is still waiting for addr_ok
        ds_allowin = 1'b0;
        mem_alat   = 5;
        cycle(d);
        cycle(d);
        reset = 1'b1;
        cycle(d);
        reset   = 1'b0;
        pend    = 1'b0;
        req_cnt = 0;
        check(!inst_sram_req && !fs_valid, "mid_reset_idle",
              {30'b0, fs_valid, inst_sram_req}, 32'h0);
        run_vec(mk(32'hBFC0_0000, 3));

        check(exp_q.size() == 0, "exp_q_drained", exp_q.size(), 32'h0);
        check(exp_addr.size() == 0, "exp_addr_drained", exp_addr.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
